filter_gate: RTL and testbench

// Downstream consumer of the 5-tuple filter's decision. It holds the head of

---
 rtl/filter_gate.sv | 145 ++++++++++++++
 tb/tb_filter_gate.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_gate.sv
// filter_gate: holds each packet on the AXI4-Stream slave until the 5-tuple
// filter's verdict is valid. It then forwards the packet unchanged or drops
// it, pulses hdr_clear after the last beat, and counts forwarded and dropped
// packets.
module filter_gate #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int HOLDOFF_CYCLES       = 2
) (
   input  logic                              axi_aclk,
   input  logic                              axi_reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   input  logic                              send,
   input  logic                              send_rd,
   output logic                              hdr_clear,
   output logic [31:0]                       pkt_fwd_cnt,
   output logic [31:0]                       pkt_drop_cnt
);

   localparam int HW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

   typedef enum logic [1:0] {
      WAIT_DEC = 2'd0,
      FWD      = 2'd1,
      DROP     = 2'd2,
      CLEAR    = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic          r_sendRdPrev;
   logic [HW-1:0] r_holdoff;
   logic [31:0]   r_fwdCnt;
   logic [31:0]   r_dropCnt;
   logic          w_decOk;
   logic          w_sReady;
   logic          w_lastHs;

   // The verdict is only trusted on the second consecutive cycle of send_rd,
   // because send itself settles one cycle after send_rd rises.
   assign w_decOk  = send_rd & r_sendRdPrev;
   assign w_lastHs = s_axis_tvalid & w_sReady & s_axis_tlast;

   // Next-state decode plus the slave/master handshake muxing for each state.
   always_comb begin
      w_nextState   = r_state;
      w_sReady      = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tuser  = '0;
      m_axis_tlast  = 1'b0;
      hdr_clear     = 1'b0;
      case (r_state)
         WAIT_DEC: begin
            if (w_decOk && (r_holdoff == '0)) begin
               w_nextState = send ? FWD : DROP;
            end
         end
         FWD: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tstrb  = s_axis_tstrb;
            m_axis_tuser  = s_axis_tuser;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tvalid = s_axis_tvalid;
            w_sReady      = m_axis_tready;
            if (w_lastHs) begin
               w_nextState = CLEAR;
            end
         end
         DROP: begin
            w_sReady = 1'b1;
            if (w_lastHs) begin
               w_nextState = CLEAR;
            end
         end
         CLEAR: begin
            hdr_clear   = 1'b1;
            w_nextState = WAIT_DEC;
         end
         default: begin
            w_nextState = WAIT_DEC;
         end
      endcase
   end

   // State register; reset abandons any packet in flight.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_state <= WAIT_DEC;
      end else begin
         r_state <= w_nextState;
      end
   end

   // send_rd history and post-clear holdoff. Clearing the history in CLEAR
   // stops the filter's lingering send_rd from looking like a fresh verdict.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_sendRdPrev <= 1'b0;
         r_holdoff    <= '0;
      end else if (r_state == CLEAR) begin
         r_sendRdPrev <= 1'b0;
         r_holdoff    <= HW'(HOLDOFF_CYCLES);
      end else begin
         r_sendRdPrev <= send_rd;
         if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - HW'(1);
         end
      end
   end

   // Packet counters bump on the last-beat handshake and wrap freely.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_fwdCnt  <= '0;
         r_dropCnt <= '0;
      end else begin
         if ((r_state == FWD) && w_lastHs) begin
            r_fwdCnt <= r_fwdCnt + 32'd1;
         end
         if ((r_state == DROP) && w_lastHs) begin
            r_dropCnt <= r_dropCnt + 32'd1;
         end
      end
   end

   assign s_axis_tready = w_sReady;
   assign pkt_fwd_cnt   = r_fwdCnt;
   assign pkt_drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_filter_gate.sv
// tb_filter_gate: scoreboard bench for filter_gate. An upstream source model
// feeds beats from a queue, a filter model raises send_rd/send per packet,
// and forwarded beats are popped from an expected queue as they appear.
module tb_filter_gate;

   localparam int DW = 256;
   localparam int SW = 32;
   localparam int UW = 128;

   logic          axi_aclk = 1'b0;
   logic          axi_reset = 1'b1;
   logic [DW-1:0] s_axis_tdata = '0;
   logic [SW-1:0] s_axis_tstrb = '0;
   logic [UW-1:0] s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic [SW-1:0] m_axis_tstrb;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic          send = 1'b0;
   logic          send_rd = 1'b0;
   logic          hdr_clear;
   logic [31:0]   pkt_fwd_cnt;
   logic [31:0]   pkt_drop_cnt;

   typedef struct {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   beat_t       srcQ[$];
   beat_t       expQ[$];
   bit          verdQ[$];
   beat_t       monBeat;
   int          nChecks = 0;
   int          nPass = 0;
   int          vState = 0;
   int          vGap = 0;
   bit          curV = 1'b0;
   bit          clearSeen = 1'b0;
   bit          srcPop = 1'b0;
   bit          pendClr = 1'b0;
   int          rdAge = 0;
   bit          readyToggle = 1'b0;
   bit          readyPhase = 1'b0;
   int          consumedBeats = 0;
   int          clearCnt = 0;
   int          expBeats = 0;
   int          expClears = 0;
   logic [31:0] expFwd = '0;
   logic [31:0] expDrop = '0;

   filter_gate dut (
      .axi_aclk      (axi_aclk),
      .axi_reset     (axi_reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .send          (send),
      .send_rd       (send_rd),
      .hdr_clear     (hdr_clear),
      .pkt_fwd_cnt   (pkt_fwd_cnt),
      .pkt_drop_cnt  (pkt_drop_cnt)
   );

   // 100 MHz clock.
   always #5 axi_aclk = ~axi_aclk;

   // Run-away guard so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      nChecks++;
      if (got === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Queue one packet at the source, its verdict at the filter model, and
   // its beats in the expected queue when it should be forwarded.
   task automatic applyStimulus(input int nBeats, input bit fwd);
      beat_t b;
      for (int i = 0; i < nBeats; i++) begin
         b.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
         b.strb = $urandom();
         b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
         b.last = (i == nBeats - 1);
         srcQ.push_back(b);
         if (fwd) expQ.push_back(b);
      end
      verdQ.push_back(fwd);
      expBeats += nBeats;
      expClears++;
      if (fwd) expFwd = expFwd + 32'd1;
      else     expDrop = expDrop + 32'd1;
   endtask

   // Wait until the source and filter models have nothing left to do.
   task automatic waitIdle(input int budget);
      int n = 0;
      while ((srcQ.size() != 0 || verdQ.size() != 0 || vState != 0 || vGap != 0) && n < budget) begin
         @(negedge axi_aclk);
         n++;
      end
      repeat (3) @(negedge axi_aclk);
      #2;
      checkOutput("idleTimeout", DW'(n >= budget), '0);
   endtask

   task automatic checkTotals(input string tag);
      checkOutput({tag, ".fwdCnt"}, DW'(pkt_fwd_cnt), DW'(expFwd));
      checkOutput({tag, ".dropCnt"}, DW'(pkt_drop_cnt), DW'(expDrop));
      checkOutput({tag, ".clears"}, DW'(clearCnt), DW'(expClears));
      checkOutput({tag, ".beatsIn"}, DW'(consumedBeats), DW'(expBeats));
      checkOutput({tag, ".expLeft"}, DW'(expQ.size()), '0);
   endtask

   // Source, sink-ready and filter-verdict drivers, updated just after each edge.
   always @(posedge axi_aclk) begin
      #1;
      if (axi_reset) begin
         srcQ.delete();
         srcPop  = 1'b0;
         vState  = 0;
         vGap    = 0;
         send_rd = 1'b0;
         send    = 1'b0;
      end else begin
         if (srcPop && srcQ.size() != 0) void'(srcQ.pop_front());
         srcPop = 1'b0;
         case (vState)
            0: begin
               if (vGap > 0) begin
                  vGap--;
               end else if (verdQ.size() != 0) begin
                  curV      = verdQ.pop_front();
                  send_rd   = 1'b1;
                  send      = ~curV;
                  clearSeen = 1'b0;
                  vState    = 1;
               end
            end
            1: begin
               send   = curV;
               vState = 2;
            end
            2: begin
               if (clearSeen) begin
                  clearSeen = 1'b0;
                  vState    = 3;
               end
            end
            default: begin
               send_rd = 1'b0;
               send    = 1'b0;
               vGap    = 2;
               vState  = 0;
            end
         endcase
      end
      if (srcQ.size() != 0) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = srcQ[0].data;
         s_axis_tstrb  = srcQ[0].strb;
         s_axis_tuser  = srcQ[0].user;
         s_axis_tlast  = srcQ[0].last;
      end else begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = '0;
         s_axis_tstrb  = '0;
         s_axis_tuser  = '0;
         s_axis_tlast  = 1'b0;
      end
      m_axis_tready = readyToggle ? readyPhase : 1'b1;
      readyPhase    = ~readyPhase;
   end

   // Mid-cycle monitor: verdict latency, hdr_clear timing, handshakes, scoreboard.
   always @(negedge axi_aclk) begin
      if (axi_reset) begin
         pendClr   = 1'b0;
         rdAge     = 0;
         srcPop    = 1'b0;
         clearSeen = 1'b0;
      end else begin
         if (send_rd) rdAge++;
         else         rdAge = 0;
         if (rdAge == 2) begin
            checkOutput("earlyValid", DW'(m_axis_tvalid), '0);
            checkOutput("earlyReady", DW'(s_axis_tready), '0);
         end
         if (rdAge == 3 && s_axis_tvalid) begin
            if (curV) checkOutput("fwdLatency", DW'(m_axis_tvalid), DW'(1));
            else      checkOutput("dropLatency", DW'(s_axis_tready), DW'(1));
         end
         if (hdr_clear || pendClr) checkOutput("hdrClearTiming", DW'(hdr_clear), DW'(pendClr));
         if (hdr_clear) begin
            clearCnt++;
            clearSeen = 1'b1;
         end
         pendClr = s_axis_tvalid & s_axis_tready & s_axis_tlast;
         if (s_axis_tvalid && s_axis_tready) begin
            srcPop = 1'b1;
            consumedBeats++;
         end
         if (m_axis_tvalid) begin
            checkOutput("readyMirror", DW'(s_axis_tready), DW'(m_axis_tready));
            if (expQ.size() == 0) begin
               checkOutput("spuriousValid", DW'(m_axis_tvalid), '0);
            end else if (m_axis_tready) begin
               monBeat = expQ.pop_front();
               checkOutput("tdata", m_axis_tdata, monBeat.data);
               checkOutput("tstrb", DW'(m_axis_tstrb), DW'(monBeat.strb));
               checkOutput("tuser", DW'(m_axis_tuser), DW'(monBeat.user));
               checkOutput("tlast", DW'(m_axis_tlast), DW'(monBeat.last));
            end
         end
      end
   end

   // Scenario sequence.
   initial begin
      int n;
      int base;
      $display("[TB] filter_gate bench starting");
      repeat (3) @(posedge axi_aclk);
      @(negedge axi_aclk);
      #2;
      axi_reset = 1'b0;

      // Idle after reset: nothing moves.
      repeat (8) @(negedge axi_aclk);
      #1;
      checkOutput("rst.sReady", DW'(s_axis_tready), '0);
      checkOutput("rst.mValid", DW'(m_axis_tvalid), '0);
      checkOutput("rst.hdrClear", DW'(hdr_clear), '0);
      checkOutput("rst.fwdCnt", DW'(pkt_fwd_cnt), '0);
      checkOutput("rst.dropCnt", DW'(pkt_drop_cnt), '0);
      #1;

      $display("[TB] 3-beat forward");
      applyStimulus(3, 1'b1);
      waitIdle(300);
      checkTotals("fwd3");

      $display("[TB] 3-beat drop");
      applyStimulus(3, 1'b0);
      waitIdle(300);
      checkTotals("drop3");

      $display("[TB] forward with toggling sink ready");
      readyToggle = 1'b1;
      applyStimulus(5, 1'b1);
      waitIdle(300);
      readyToggle = 1'b0;
      checkTotals("toggle");

      $display("[TB] back-to-back single-beat packets");
      applyStimulus(1, 1'b1);
      applyStimulus(1, 1'b0);
      applyStimulus(1, 1'b1);
      waitIdle(500);
      checkTotals("single");

      $display("[TB] reset in the middle of a forwarded packet");
      base = consumedBeats;
      applyStimulus(4, 1'b1);
      n = 0;
      while (consumedBeats < base + 1 && n < 200) begin
         @(negedge axi_aclk);
         #1;
         n++;
      end
      checkOutput("midPktTimeout", DW'(n >= 200), '0);
      #1;
      axi_reset = 1'b1;
      @(posedge axi_aclk);
      #3;
      expQ.delete();
      verdQ.delete();
      expFwd        = '0;
      expDrop       = '0;
      expBeats      = 0;
      expClears     = 0;
      consumedBeats = 0;
      clearCnt      = 0;
      @(negedge axi_aclk);
      #1;
      checkOutput("midRst.sReady", DW'(s_axis_tready), '0);
      checkOutput("midRst.mValid", DW'(m_axis_tvalid), '0);
      checkOutput("midRst.hdrClear", DW'(hdr_clear), '0);
      checkOutput("midRst.fwdCnt", DW'(pkt_fwd_cnt), '0);
      checkOutput("midRst.dropCnt", DW'(pkt_drop_cnt), '0);
      #1;
      axi_reset = 1'b0;
      applyStimulus(2, 1'b1);
      waitIdle(300);
      checkTotals("afterRst");

      $display("[TB] forwarded-counter wrap");
      force dut.r_fwdCnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_fwdCnt;
      expFwd = 32'hFFFF_FFFF;
      applyStimulus(1, 1'b1);
      waitIdle(300);
      checkOutput("wrap.fwdCnt", DW'(pkt_fwd_cnt), '0);
      checkTotals("wrap");

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
